imuldiv_int_div_iterative: RTL

- Iterative 32-bit integer divide/remainder unit; the inverse operation to the team's iterative multiplier.
- Sits beside the multiplier in the imuldiv block and uses the same val/rdy request/response handshake.
- Performs one restoring-division step per cycle over 32 cycles and returns {remainder, quotient} in one 64-bit response.
- Supports signed and unsigned operation, selected per request.

---
 rtl/imuldiv_pkg.sv | 23 ++
 rtl/imuldiv_int_div_iterative_dpath.sv | 70 +++++++
 rtl/imuldiv_int_div_iterative.sv | 79 +++++++
 3 files changed

// File: rtl/imuldiv_pkg.sv
// Shared constants and types for the imuldiv block: FSM encodings, function
// codes and the divider iteration parameters.
package imuldiv_pkg;

  localparam int DIV_W     = 32;
  localparam int DIV_ITERS = 32;
  localparam int CNT_W     = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_e;

  localparam logic FN_SIGNED   = 1'b0;
  localparam logic FN_UNSIGNED = 1'b1;

  // Two's-complement negate when neg is set, otherwise pass through.
  function automatic logic [DIV_W-1:0] neg_if(input logic neg, input logic [DIV_W-1:0] v);
    return neg ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/imuldiv_int_div_iterative_dpath.sv
// Restoring-division datapath: operand capture, one shift/subtract step per
// enabled cycle, and sign/divide-by-zero fix-up of the final result.
module imuldiv_int_div_iterative_dpath
  import imuldiv_pkg::*;
(
  input  logic              clk,
  input  logic              en,
  input  logic              init_sel,
  input  logic              fn,
  input  logic [DIV_W-1:0]  a,
  input  logic [DIV_W-1:0]  b,
  output logic [63:0]       result
);

  logic              sign_a;
  logic              sign_b;
  logic              b_zero;
  logic [DIV_W-1:0]  a_raw;
  logic [64:0]       rem_reg;
  logic [64:0]       div_reg;

  logic              sa_in;
  logic              sb_in;
  logic [64:0]       sh;
  logic [64:0]       diff;
  logic [DIV_W-1:0]  uq;
  logic [DIV_W-1:0]  ur;
  logic [DIV_W-1:0]  quot;
  logic [DIV_W-1:0]  rem;

  assign sa_in = a[DIV_W-1] & ~fn;
  assign sb_in = b[DIV_W-1] & ~fn;

  assign sh   = rem_reg << 1;
  assign diff = sh - div_reg;

  always_ff @(posedge clk) begin
    if (en) begin
      if (init_sel) begin
        sign_a  <= sa_in;
        sign_b  <= sb_in;
        b_zero  <= (b == '0);
        a_raw   <= a;
        rem_reg <= {33'b0, neg_if(sa_in, a)};
        div_reg <= {1'b0, neg_if(sb_in, b), 32'b0};
      end else if (diff[64]) begin
        rem_reg <= sh;
      end else begin
        // diff[0] is always 0 (both sh and div_reg have a zero LSB), so OR-ing
        // in the quotient bit is the same as replacing it.
        rem_reg <= diff | 65'd1;
      end
    end
  end

  assign uq = rem_reg[31:0];
  assign ur = rem_reg[63:32];

  always_comb begin
    quot = neg_if(sign_a ^ sign_b, uq);
    rem  = neg_if(sign_a, ur);
    if (b_zero) begin
      quot = '1;
      rem  = a_raw;
    end
  end

  assign result = {rem, quot};

endmodule

// File: rtl/imuldiv_int_div_iterative.sv
// Iterative 32-bit signed/unsigned divider: control FSM and step counter
// around the restoring-division datapath; returns {remainder, quotient}.
module imuldiv_int_div_iterative
  import imuldiv_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              divreq_msg_fn,
  input  logic [DIV_W-1:0]  divreq_msg_a,
  input  logic [DIV_W-1:0]  divreq_msg_b,
  input  logic              divreq_val,
  output logic              divreq_rdy,
  output logic [63:0]       divresp_msg_result,
  output logic              divresp_val,
  input  logic              divresp_rdy
);

  // Handshake: a transfer happens on a rising edge where val && rdy are both
  // high; val never waits on rdy, and the result is held stable while
  // divresp_val is high until the transfer completes.

  div_state_e        state;
  logic [CNT_W-1:0]  count;
  logic              accept;
  logic              dp_en;

  assign accept = (state == IDLE) && divreq_val && divreq_rdy;
  assign dp_en  = accept || (state == CALC);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      count       <= '0;
      divreq_rdy  <= 1'b1;
      divresp_val <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state      <= CALC;
            count      <= '0;
            divreq_rdy <= 1'b0;
          end
        end
        CALC: begin
          count <= count + 6'd1;
          if (count == CNT_W'(DIV_ITERS - 1)) begin
            state       <= DONE;
            divresp_val <= 1'b1;
          end
        end
        DONE: begin
          if (divresp_rdy) begin
            state       <= IDLE;
            divresp_val <= 1'b0;
            divreq_rdy  <= 1'b1;
          end
        end
        default: begin
          state       <= IDLE;
          count       <= '0;
          divreq_rdy  <= 1'b1;
          divresp_val <= 1'b0;
        end
      endcase
    end
  end

  imuldiv_int_div_iterative_dpath u_dpath (
    .clk      (clk),
    .en       (dp_en),
    .init_sel (accept),
    .fn       (divreq_msg_fn),
    .a        (divreq_msg_a),
    .b        (divreq_msg_b),
    .result   (divresp_msg_result)
  );

endmodule
